// File: rtl/ahb_master_if.sv
// ============================================================================
//  Module   : ahb_master_if
//  Purpose  : AHB initiator engine for one CPU master port. Single or
//             BURST_LEN-beat word requests, bus arbitration, pipelined
//             address/data phases and ERROR/RETRY/SPLIT handling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_master_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  input  logic              HGRANT,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              HBUSREQ,
  output logic              HLOCK,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA
);

  localparam int CW = $clog2(BURST_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
  localparam logic [2:0] S_RTY  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  logic [2:0]        r_state;
  logic              r_req_ready;
  logic              r_burst;
  logic [CW-1:0]     r_abeat;
  logic [CW-1:0]     r_dbeat;
  logic              r_dvalid;
  logic              r_dlast;
  logic [ADDR_W-1:0] r_daddr;
  logic              r_reissue;
  logic              r_hbusreq, r_hlock, r_hwrite;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic [2:0]        r_hsize;
  logic [DATA_W-1:0] r_hwdata, r_rdata;
  logic              r_rdata_valid, r_done, r_err, r_wdata_pop;

  logic              w_alast;
  logic              w_dok;
  logic              w_dfail;
  logic [ADDR_W-1:0] w_naddr;

  assign w_alast = r_burst ? (r_abeat == CW'(BURST_LEN - 1)) : 1'b1;
  assign w_dok   = r_dvalid && HREADY && (HRESP == RSP_OKAY);
  assign w_dfail = r_dvalid && !HREADY && (HRESP != RSP_OKAY);
  assign w_naddr = r_haddr + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_burst       <= 1'b0;
      r_abeat       <= '0;
      r_dbeat       <= '0;
      r_dvalid      <= 1'b0;
      r_dlast       <= 1'b0;
      r_daddr       <= '0;
      r_reissue     <= 1'b0;
      r_hbusreq     <= 1'b0;
      r_hlock       <= 1'b0;
      r_hwrite      <= 1'b0;
      r_haddr       <= '0;
      r_htrans      <= TR_IDLE;
      r_hsize       <= 3'b000;
      r_hwdata      <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_wdata_pop   <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_wdata_pop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_burst     <= req_burst;
            r_hwrite    <= req_write;
            r_haddr     <= req_addr;
            r_hsize     <= req_burst ? 3'b010 : req_size;
            r_abeat     <= '0;
            r_dvalid    <= 1'b0;
            r_reissue   <= 1'b0;
            r_hbusreq   <= 1'b1;
            r_hlock     <= req_burst;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (HGRANT && HREADY) begin
            r_htrans <= TR_NONSEQ;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR, S_DATA: begin
          if (w_dfail) begin
            // First response cycle of ERROR/RETRY/SPLIT: withdraw the pending address
            r_htrans <= TR_IDLE;
            r_dvalid <= 1'b0;
            if (HRESP == RSP_ERROR) begin
              r_hbusreq <= 1'b0;
              r_hlock   <= 1'b0;
              r_state   <= S_ERR;
            end else begin
              r_state <= S_RTY;
            end
          end else if (HREADY) begin
            if (w_dok && !r_hwrite) begin
              r_rdata       <= HRDATA;
              r_rdata_valid <= 1'b1;
            end
            if (r_state == S_ADDR) begin
              r_dvalid <= 1'b1;
              r_daddr  <= r_haddr;
              r_dbeat  <= r_abeat;
              r_dlast  <= w_alast;
              // A re-issued beat keeps the write data already held on HWDATA
              if (r_reissue) begin
                r_reissue <= 1'b0;
              end else if (r_hwrite) begin
                r_hwdata    <= wdata;
                r_wdata_pop <= 1'b1;
              end
              if (w_alast) begin
                r_htrans  <= TR_IDLE;
                r_hbusreq <= 1'b0;
                r_hlock   <= 1'b0;
                r_state   <= S_DATA;
              end else begin
                r_haddr <= w_naddr;
                r_abeat <= r_abeat + CW'(1);
                if (HGRANT) begin
                  r_htrans <= TR_SEQ;
                end else begin
                  r_htrans <= TR_IDLE;
                  r_state  <= S_DATA;
                end
              end
            end else begin
              r_dvalid <= 1'b0;
              r_state  <= r_dlast ? S_FIN : S_REQ;
            end
          end
        end
        S_ERR: begin
          if (HREADY) begin
            r_done      <= 1'b1;
            r_err       <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_RTY: begin
          if (HREADY) begin
            r_haddr   <= r_daddr;
            r_abeat   <= r_dbeat;
            r_reissue <= 1'b1;
            r_hbusreq <= 1'b1;
            r_hlock   <= r_burst;
            r_state   <= S_REQ;
          end
        end
        S_FIN: begin
          r_done      <= 1'b1;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign wdata_pop   = r_wdata_pop;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;
  assign HBUSREQ     = r_hbusreq;
  assign HLOCK       = r_hlock;
  assign HADDR       = r_haddr;
  assign HTRANS      = r_htrans;
  assign HSIZE       = r_hsize;
  assign HWRITE      = r_hwrite;
  assign HWDATA      = r_hwdata;

endmodule

`default_nettype wire
